// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// sticky overflow/underflow errors and a synchronous flush.
module sync_fifo_param #(
  parameter int WIDTH    = 9,
  parameter int DEPTH    = 256,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4,
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             wr_ok;
  logic             rd_ok;

  // A write into a full FIFO is still taken when a read frees a slot the same cycle.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  // Flags decode the registered count only, so no input reaches an output combinationally.
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  always_ff @(posedge clk) begin
    if (rst && !flush && wr_ok) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (flush) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_ok) begin
        dout <= mem[rptr];
        rptr <= rptr + 1'b1;
      end
      dout_valid <= rd_ok;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_en && !wr_ok) begin
        overflow <= 1'b1;
      end
      if (rd_en && !rd_ok) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised and directed bench for sync_fifo_param against a queue-based
// reference model of the FIFO's occupancy and error rules.
module tb_sync_fifo_param;
  localparam int W  = 9;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 2;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [W-1:0]  din = '0;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  sync_fifo_param #(
    .WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .din(din),
    .rd_en(rd_en), .dout(dout), .dout_valid(dout_valid), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int q[$];
  int m_dout  = 0;
  bit m_valid = 1'b0;
  bit m_ovf   = 1'b0;
  bit m_udf   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, advance the model at posedge, compare 1ns later.
  task automatic step(input bit w, input bit r, input bit f, input bit rs, input int d);
    bit rd_ok;
    bit wr_ok;
    @(negedge clk);
    wr_en = w; rd_en = r; flush = f; rst = rs; din = d[W-1:0];
    @(posedge clk);
    if (!rs) begin
      q.delete(); m_dout = 0; m_valid = 0; m_ovf = 0; m_udf = 0;
    end else if (f) begin
      q.delete(); m_valid = 0; m_ovf = 0; m_udf = 0;
    end else begin
      rd_ok = r && (q.size() > 0);
      wr_ok = w && (q.size() < D || rd_ok);
      if (rd_ok) m_dout = q.pop_front();
      m_valid = rd_ok;
      if (wr_ok) q.push_back(d & ((1 << W) - 1));
      if (w && !wr_ok) m_ovf = 1;
      if (r && !rd_ok) m_udf = 1;
    end
    #1;
    chk("dout",         32'(dout),         32'(m_dout));
    chk("dout_valid",   32'(dout_valid),   32'(m_valid));
    chk("count",        32'(count),        32'(q.size()));
    chk("full",         32'(full),         32'(q.size() == D));
    chk("empty",        32'(empty),        32'(q.size() == 0));
    chk("almost_full",  32'(almost_full),  32'(q.size() >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(q.size() <= AE));
    chk("overflow",     32'(overflow),     32'(m_ovf));
    chk("underflow",    32'(underflow),    32'(m_udf));
  endtask

  initial begin
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Fill, then one write too many
    for (int i = 1; i <= 8; i++) step(1, 0, 0, 1, 'h100 + i);
    step(1, 0, 0, 1, 'h1FF);
    chk("fill_ovf", 32'(overflow), 32'd1);

    // Drain, then one read too many
    for (int i = 0; i < 8; i++) step(0, 1, 0, 1, 0);
    step(0, 1, 0, 1, 0);
    chk("drain_hold", 32'(dout), 32'h108);

    // Concurrent access at full, then at empty
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 1, 'h10 + i);
    step(1, 1, 0, 1, 'h1AA);
    chk("full_rw_dout", 32'(dout), 32'h10);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 1, 0);
    step(1, 1, 0, 1, 'h055);
    step(0, 1, 0, 1, 0);
    chk("empty_rw_data", 32'(dout), 32'h055);

    // Streaming across the pointer wrap at count 3
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 'h40 + i);
    for (int i = 0; i < 20; i++) step(1, 1, 0, 1, 'h60 + i);
    chk("wrap_count", 32'(count), 32'd3);

    // Flush with count 5 and overflow set, a write alongside it
    for (int i = 0; i < 6; i++) step(1, 0, 0, 1, 'h80 + i);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 1, 0);
    chk("pre_flush_ovf", 32'(overflow), 32'd1);
    step(1, 0, 1, 1, 'h1EE);
    chk("flush_count", 32'(count), 32'd0);

    // Reset while streaming reads
    for (int i = 0; i < 6; i++) step(1, 0, 0, 1, 'hC0 + i);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    chk("rst_dout", 32'(dout), 32'd0);
    step(0, 1, 0, 1, 0);
    chk("rst_udf", 32'(underflow), 32'd1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bit w, r, f, rs;
      w  = ($urandom_range(99) < 55);
      r  = ($urandom_range(99) < 50);
      f  = ($urandom_range(99) < 2);
      rs = ($urandom_range(199) != 0);
      step(w, r, f, rs, int'($urandom_range(511)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
